// File: rtl/soc_mux_ahb3.sv
// Round-robin AHB3-Lite multi-master mux with lock/burst tenure and per-master address hold.
// Latency: owner passes through combinationally; a held (non-owner) request issues one cycle after capture at the earliest.
// Backpressure: a master with a pending hold sees HREADY low; target wait states freeze arbitration and the data phase.
module soc_mux_ahb3 #(
  parameter int MASTERS = 2,
  parameter int XLEN    = 32,
  parameter int PLEN    = 32,
  localparam int SW     = XLEN >> 3
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [MASTERS-1:0]             m_hsel_i,
  input  logic [MASTERS-1:0][PLEN-1:0]   m_haddr_i,
  input  logic [MASTERS-1:0][XLEN-1:0]   m_hwdata_i,
  input  logic [MASTERS-1:0]             m_hwrite_i,
  input  logic [MASTERS-1:0][2:0]        m_hsize_i,
  input  logic [MASTERS-1:0][2:0]        m_hburst_i,
  input  logic [MASTERS-1:0][SW-1:0]     m_hprot_i,
  input  logic [MASTERS-1:0][1:0]        m_htrans_i,
  input  logic [MASTERS-1:0]             m_hmastlock_i,
  output logic [MASTERS-1:0][XLEN-1:0]   m_hrdata_o,
  output logic [MASTERS-1:0]             m_hready_o,
  output logic [MASTERS-1:0]             m_hresp_o,
  output logic                           s_hsel_o,
  output logic [PLEN-1:0]                s_haddr_o,
  output logic [XLEN-1:0]                s_hwdata_o,
  output logic                           s_hwrite_o,
  output logic [2:0]                     s_hsize_o,
  output logic [2:0]                     s_hburst_o,
  output logic [SW-1:0]                  s_hprot_o,
  output logic [1:0]                     s_htrans_o,
  output logic                           s_hmastlock_o,
  input  logic [XLEN-1:0]                s_hrdata_i,
  input  logic                           s_hready_i,
  input  logic                           s_hresp_i
);

  localparam int IW = $clog2(MASTERS);
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef struct packed {
    logic [PLEN-1:0] addr;
    logic            write;
    logic [2:0]      size;
    logic [2:0]      burst;
    logic [SW-1:0]   prot;
    logic [1:0]      trans;
    logic            lock;
  } hdr_t;

  hdr_t               live   [MASTERS];
  hdr_t               hold_q [MASTERS];
  hdr_t               src;
  logic [MASTERS-1:0] req;
  logic [MASTERS-1:0] capture;
  logic [MASTERS-1:0] pending_q, pending_d;
  logic [IW-1:0]      owner_q, owner_d, downer_q;
  logic               dvalid_q;
  logic               src_req;
  logic               keep;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % MASTERS;
    return IW'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < MASTERS; i++) begin
      live[i] = '{addr:  m_haddr_i[i],  write: m_hwrite_i[i], size: m_hsize_i[i],
                  burst: m_hburst_i[i], prot:  m_hprot_i[i],  trans: m_htrans_i[i],
                  lock:  m_hmastlock_i[i]};
      req[i]  = m_hsel_i[i] & m_htrans_i[i][1];
    end
  end

  // A pending owner always has a valid held request, so the hold wins over live inputs.
  always_comb begin
    src     = pending_q[owner_q] ? hold_q[owner_q] : live[owner_q];
    src_req = pending_q[owner_q] | req[owner_q];
  end

  always_comb begin
    s_hsel_o      = src_req & rst_ni;
    s_haddr_o     = src.addr;
    s_hwrite_o    = src.write;
    s_hsize_o     = src.size;
    s_hburst_o    = src.burst;
    s_hprot_o     = src.prot;
    s_htrans_o    = (src_req & rst_ni) ? src.trans : HTRANS_IDLE;
    s_hmastlock_o = src.lock & rst_ni;
    s_hwdata_o    = m_hwdata_i[downer_q];
  end

  always_comb begin
    for (int i = 0; i < MASTERS; i++) begin
      m_hrdata_o[i] = s_hrdata_i;
      if (dvalid_q && downer_q == IW'(i)) begin
        m_hready_o[i] = s_hready_i;
        m_hresp_o[i]  = s_hresp_i;
      end else begin
        m_hready_o[i] = ~pending_q[i];
        m_hresp_o[i]  = 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < MASTERS; i++) begin
      capture[i]   = req[i] & m_hready_o[i] & ((owner_q != IW'(i)) | ~s_hready_i);
      pending_d[i] = pending_q[i];
      if (capture[i])
        pending_d[i] = 1'b1;
      else if (owner_q == IW'(i) && s_hready_i)
        pending_d[i] = 1'b0;
    end
  end

  // Tenure: locked transfers and unfinished bursts keep the grant with the current owner.
  always_comb begin
    keep    = src.lock | ((src.burst != HBURST_SINGLE) & (src.trans != HTRANS_IDLE));
    owner_d = owner_q;
    if (s_hready_i && !keep) begin
      for (int k = MASTERS; k >= 1; k--) begin
        if (pending_d[rr_idx(owner_q, k)])
          owner_d = rr_idx(owner_q, k);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      owner_q   <= '0;
      downer_q  <= '0;
      dvalid_q  <= 1'b0;
      for (int i = 0; i < MASTERS; i++)
        hold_q[i] <= '0;
    end else begin
      pending_q <= pending_d;
      owner_q   <= owner_d;
      for (int i = 0; i < MASTERS; i++)
        if (capture[i])
          hold_q[i] <= live[i];
      if (s_hready_i) begin
        dvalid_q <= src_req;
        downer_q <= owner_q;
      end
    end
  end

endmodule

// File: tb/tb_soc_mux_ahb3.sv
// Bench for soc_mux_ahb3 with three masters: a queue-based transaction model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_soc_mux_ahb3;

  localparam int NM = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [NM-1:0]        m_hsel, m_hwrite, m_hmastlock, m_hready, m_hresp;
  logic [NM-1:0][31:0]  m_haddr, m_hwdata, m_hrdata;
  logic [NM-1:0][2:0]   m_hsize, m_hburst;
  logic [NM-1:0][3:0]   m_hprot;
  logic [NM-1:0][1:0]   m_htrans;
  logic        s_hsel, s_hwrite, s_hmastlock, s_hready, s_hresp;
  logic [31:0] s_haddr, s_hwdata, s_hrdata;
  logic [2:0]  s_hsize, s_hburst;
  logic [3:0]  s_hprot;
  logic [1:0]  s_htrans;

  int n_chk  = 0;
  int n_fail = 0;

  soc_mux_ahb3 #(.MASTERS(NM), .XLEN(32), .PLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_hsel_i(m_hsel), .m_haddr_i(m_haddr), .m_hwdata_i(m_hwdata), .m_hwrite_i(m_hwrite),
    .m_hsize_i(m_hsize), .m_hburst_i(m_hburst), .m_hprot_i(m_hprot), .m_htrans_i(m_htrans),
    .m_hmastlock_i(m_hmastlock), .m_hrdata_o(m_hrdata), .m_hready_o(m_hready), .m_hresp_o(m_hresp),
    .s_hsel_o(s_hsel), .s_haddr_o(s_haddr), .s_hwdata_o(s_hwdata), .s_hwrite_o(s_hwrite),
    .s_hsize_o(s_hsize), .s_hburst_o(s_hburst), .s_hprot_o(s_hprot), .s_htrans_o(s_htrans),
    .s_hmastlock_o(s_hmastlock), .s_hrdata_i(s_hrdata), .s_hready_i(s_hready), .s_hresp_i(s_hresp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [1:0]  trans;
    logic        lock;
  } xfer_t;

  xfer_t held [NM][$];
  int    own    = 0;
  int    downer = 0;
  bit    dval   = 1'b0;

  xfer_t       e_src;
  bit          e_from_hold;
  logic        e_hsel, e_lock;
  logic [1:0]  e_trans;
  logic [NM-1:0] e_hready, e_hresp;
  logic [31:0] e_hwdata;

  function automatic xfer_t live_x(input int i);
    return '{addr: m_haddr[i], wr: m_hwrite[i], size: m_hsize[i], burst: m_hburst[i],
             prot: m_hprot[i], trans: m_htrans[i], lock: m_hmastlock[i]};
  endfunction

  function automatic bit live_req(input int i);
    return m_hsel[i] && (m_htrans[i] == 2'b10 || m_htrans[i] == 2'b11);
  endfunction

  task automatic model_eval();
    e_from_hold = held[own].size() != 0;
    e_src       = e_from_hold ? held[own][0] : live_x(own);
    e_hsel      = rst_n && (e_from_hold || live_req(own));
    e_trans     = e_hsel ? e_src.trans : 2'b00;
    e_lock      = rst_n ? e_src.lock : 1'b0;
    e_hwdata    = m_hwdata[downer];
    for (int i = 0; i < NM; i++) begin
      if (dval && downer == i) begin
        e_hready[i] = s_hready;
        e_hresp[i]  = s_hresp;
      end else begin
        e_hready[i] = held[i].size() == 0;
        e_hresp[i]  = 1'b0;
      end
    end
  endtask

  task automatic model_step();
    xfer_t s;
    bit    fh;
    int    o;
    model_eval();
    s  = e_src;
    fh = e_from_hold;
    o  = own;
    for (int i = 0; i < NM; i++)
      if (live_req(i) && e_hready[i] && (i != o || !s_hready))
        held[i].push_back(live_x(i));
    if (s_hready) begin
      if (fh) void'(held[o].pop_front());
      dval   = e_hsel;
      downer = o;
      if (!(s.lock || (s.burst != 3'd0 && s.trans != 2'b00)))
        for (int k = 1; k <= NM; k++)
          if (own == o && held[(o + k) % NM].size() != 0)
            own = (o + k) % NM;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < NM; i++) held[i].delete();
      own = 0; downer = 0; dval = 1'b0;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison against the model, well away from the rising edge.
  always @(negedge clk) begin
    #2;
    model_eval();
    chk("cmp_hsel", s_hsel, e_hsel);
    chk("cmp_htrans", s_htrans, e_trans);
    chk("cmp_hmastlock", s_hmastlock, e_lock);
    chk("cmp_m_hready", m_hready, e_hready);
    chk("cmp_m_hresp", m_hresp, e_hresp);
    chk("cmp_hwdata", s_hwdata, e_hwdata);
    for (int i = 0; i < NM; i++) chk("cmp_hrdata", m_hrdata[i], s_hrdata);
    if (e_hsel) begin
      chk("cmp_haddr", s_haddr, e_src.addr);
      chk("cmp_hwrite", s_hwrite, e_src.wr);
      chk("cmp_hsize", s_hsize, e_src.size);
      chk("cmp_hburst", s_hburst, e_src.burst);
      chk("cmp_hprot", s_hprot, e_src.prot);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_all();
    m_hsel = '0; m_htrans = '0; m_hmastlock = '0; m_hburst = '0;
    m_haddr = '0; m_hwrite = '0; m_hsize = '0; m_hprot = '0;
  endtask

  task automatic drv(input int i, input logic [31:0] a, input logic [1:0] tr,
                     input logic [2:0] bu, input logic lk);
    m_hsel[i] = 1'b1; m_haddr[i] = a; m_hwrite[i] = a[2]; m_htrans[i] = tr;
    m_hburst[i] = bu; m_hmastlock[i] = lk; m_hsize[i] = 3'd2; m_hprot[i] = 4'(3 + i);
  endtask

  task automatic cyc();
    @(negedge clk);
    idle_all();
    s_hrdata = s_hrdata + 32'h0101_0101;
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  localparam logic [1:0] NSQ = 2'b10, SEQ = 2'b11;
  int rr_exp [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    idle_all();
    for (int i = 0; i < NM; i++) m_hwdata[i] = 32'hDA7A_0000 + 32'(i);
    s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = 32'h5EED_0000;

    // reset state
    @(negedge clk); #2;
    chk("rst_m_hready", m_hready, 3'b111);
    chk("rst_m_hresp", m_hresp, 3'b000);
    chk("rst_s_hsel", s_hsel, 1'b0);
    chk("rst_s_htrans", s_htrans, 2'b00);
    chk("rst_s_hmastlock", s_hmastlock, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // owner zero latency
    cyc(); drv(0, 32'h100, NSQ, 3'd0, 1'b0); #2;
    chk("own_haddr", s_haddr, 32'h100);
    chk("own_htrans", s_htrans, 2'b10);
    cyc(); m_hwdata[0] = 32'hCAFE_F00D; #2;
    chk("own_hwdata", s_hwdata, 32'hCAFE_F00D);
    chk("own_hready0", m_hready[0], 1'b1);

    // contention: master0 owns, master1 is held and issued next cycle
    cyc(); drv(0, 32'h200, NSQ, 3'd0, 1'b0); drv(1, 32'h300, NSQ, 3'd0, 1'b0); #2;
    chk("cont_haddr_t0", s_haddr, 32'h200);
    cyc(); #2;
    chk("cont_haddr_t1", s_haddr, 32'h300);
    chk("cont_htrans_t1", s_htrans, 2'b10);
    chk("cont_hready_t1", m_hready, 3'b101);
    cyc(); #2;
    chk("cont_hready_t2", m_hready, 3'b111);

    // lock tenure (owner is parked on master1 here)
    cyc(); drv(0, 32'h400, NSQ, 3'd1, 1'b1); #2;
    chk("lock_l0_htrans", s_htrans, 2'b00);
    cyc(); drv(0, 32'h400, NSQ, 3'd1, 1'b1); drv(1, 32'h500, NSQ, 3'd0, 1'b0); #2;
    chk("lock_l1_haddr", s_haddr, 32'h400);
    chk("lock_l1_hmastlock", s_hmastlock, 1'b1);
    cyc(); drv(0, 32'h404, SEQ, 3'd1, 1'b1); drv(1, 32'h500, NSQ, 3'd0, 1'b0); #2;
    chk("lock_l2_haddr", s_haddr, 32'h404);
    chk("lock_l2_hready1", m_hready[1], 1'b0);
    cyc(); drv(0, 32'h408, SEQ, 3'd1, 1'b1); drv(1, 32'h500, NSQ, 3'd0, 1'b0); #2;
    chk("lock_l3_haddr", s_haddr, 32'h408);
    cyc(); drv(1, 32'h500, NSQ, 3'd0, 1'b0); #2;
    chk("lock_l4_htrans", s_htrans, 2'b00);
    chk("lock_l4_hready1", m_hready[1], 1'b0);
    cyc(); drv(1, 32'h500, NSQ, 3'd0, 1'b0); #2;
    chk("lock_l5_haddr", s_haddr, 32'h500);
    chk("lock_l5_htrans", s_htrans, 2'b10);
    cyc(); #2;
    chk("lock_l6_hready1", m_hready[1], 1'b1);

    // round-robin with three continuously requesting masters
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cyc();
      for (int i = 0; i < NM; i++) drv(i, 32'h1000 * (i + 1), NSQ, 3'd0, 1'b0);
      #2;
      chk("rr_htrans", s_htrans, 2'b10);
      chk("rr_order", {28'h0, s_haddr[15:12]}, 32'(rr_exp[k] + 1));
    end
    repeat (5) cyc();

    // wait states and error response on master0's data phase
    do_reset();
    cyc(); drv(0, 32'h600, NSQ, 3'd0, 1'b0); #2;
    chk("ws_w0_haddr", s_haddr, 32'h600);
    cyc(); drv(1, 32'h700, NSQ, 3'd0, 1'b0); s_hready = 1'b0; #2;
    chk("ws_w1_hready0", m_hready[0], 1'b0);
    cyc(); drv(1, 32'h700, NSQ, 3'd0, 1'b0); #2;
    chk("ws_w2_hready", m_hready, 3'b100);
    chk("ws_w2_htrans", s_htrans, 2'b00);
    cyc(); drv(1, 32'h700, NSQ, 3'd0, 1'b0); s_hresp = 1'b1; #2;
    chk("err_w3_hresp", m_hresp, 3'b001);
    chk("err_w3_hready0", m_hready[0], 1'b0);
    cyc(); drv(1, 32'h700, NSQ, 3'd0, 1'b0); s_hready = 1'b1; #2;
    chk("err_w4_hresp", m_hresp, 3'b001);
    chk("err_w4_hready0", m_hready[0], 1'b1);
    cyc(); drv(1, 32'h700, NSQ, 3'd0, 1'b0); s_hresp = 1'b0; #2;
    chk("err_w5_haddr", s_haddr, 32'h700);
    chk("err_w5_hresp", m_hresp, 3'b000);
    cyc();

    // asynchronous reset with master1 pending
    do_reset();
    cyc(); drv(0, 32'h800, NSQ, 3'd0, 1'b0); drv(1, 32'h900, NSQ, 3'd0, 1'b0); #2;
    chk("rst_x0_haddr", s_haddr, 32'h800);
    cyc(); drv(1, 32'h900, NSQ, 3'd0, 1'b0); #2;
    chk("rst_x1_pending1", m_hready[1], 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_hready", m_hready, 3'b111);
    chk("rst_async_htrans", s_htrans, 2'b00);
    chk("rst_async_hsel", s_hsel, 1'b0);
    cyc();
    cyc(); rst_n = 1'b1; #2;
    chk("rst_y0_htrans", s_htrans, 2'b00);
    chk("rst_y0_hready", m_hready, 3'b111);
    cyc(); #2;
    chk("rst_y1_htrans", s_htrans, 2'b00);
    chk("rst_y1_hready", m_hready, 3'b111);
    cyc(); #3;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
